// File: rtl/eth_cfg_pkg.sv
// Shared types and register map for the eth_rgmii configuration sequencer.
// seq_entry() maps a write index to its register offset and payload; it is
// the single place that knows how the MAC/ctrl/length/kick fields are packed.
package eth_cfg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WR    = 3'd1,
        ST_WRESP = 3'd2,
        ST_RD    = 3'd3,
        ST_RRESP = 3'd4,
        ST_DONE  = 3'd5,
        ST_ERR   = 3'd6
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE     = 2'd0,
        ERR_RESP     = 2'd1,
        ERR_TIMEOUT  = 2'd2,
        ERR_MISMATCH = 2'd3
    } err_code_e;

    localparam logic [7:0] REG_MAC_LO = 8'h00;
    localparam logic [7:0] REG_MAC_HI = 8'h08;
    localparam logic [7:0] REG_TX_LEN = 8'h10;
    localparam logic [7:0] REG_KICK   = 8'h28;

    typedef struct packed {
        logic [7:0]  offset;
        logic [31:0] data;
    } seq_entry_t;

    // Register offset and 32-bit payload of write number idx.
    function automatic seq_entry_t seq_entry(
        input logic [1:0]  idx,
        input logic [47:0] mac,
        input logic [7:0]  ctrl,
        input logic [15:0] tx_len,
        input logic [31:0] kick
    );
        seq_entry_t e;
        e.offset = REG_MAC_LO;
        e.data   = mac[31:0];
        case (idx)
            2'd0: begin
                e.offset = REG_MAC_LO;
                e.data   = mac[31:0];
            end
            2'd1: begin
                e.offset = REG_MAC_HI;
                e.data   = {8'h00, ctrl, mac[47:32]};
            end
            2'd2: begin
                e.offset = REG_TX_LEN;
                e.data   = {16'h0000, tx_len};
            end
            default: begin
                e.offset = REG_KICK;
                e.data   = kick;
            end
        endcase
        return e;
    endfunction

endpackage

// File: rtl/eth_cfg_sequencer_timeout.sv
// Per-transaction watchdog: cleared by load_i, counts while en_i, and flags
// expiry once LIMIT active cycles have elapsed since the last load.
module eth_cfg_sequencer_timeout #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic load_i,
    input  logic en_i,
    output logic expired_o
);
    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expired_o = (cnt_q == CW'(LIMIT - 1));

    // Load has priority; the count saturates at the expiry value.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i && !expired_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/eth_cfg_sequencer.sv
// AXI write master that programs an eth_rgmii MAC: MAC low, MAC high/ctrl,
// TX length, TX kick, each a single-beat write, then pulses done_o or err_o.
// Optional feature macro: ETH_CFG_READBACK_EN reads back each non-kick
// register after its write and aborts on a data mismatch.
// Handshake rule on every channel: a transfer happens on a rising edge where
// valid and ready are both 1; a master valid is held, with stable payload,
// until that edge, except when the watchdog aborts the transaction.
module eth_cfg_sequencer
    import eth_cfg_pkg::*;
#(
    parameter int             AW          = 32,
    parameter int             DW          = 64,
    parameter int             IW          = 8,
    parameter logic [AW-1:0]  BASE_ADDR   = 'h800,
    parameter int             TIMEOUT_CYC = 1024
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [47:0]       mac_addr_i,
    input  logic [7:0]        ctrl_i,
    input  logic [15:0]       tx_len_i,
    input  logic [31:0]       kick_val_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [1:0]        err_code_o,
    output logic [1:0]        err_idx_o,
    output logic              aw_valid_o,
    input  logic              aw_ready_i,
    output logic [AW-1:0]     aw_addr_o,
    output logic [IW-1:0]     aw_id_o,
    output logic              w_valid_o,
    input  logic              w_ready_i,
    output logic [DW-1:0]     w_data_o,
    output logic [DW/8-1:0]   w_strb_o,
    output logic              w_last_o,
    input  logic              b_valid_i,
    output logic              b_ready_o,
    input  logic [1:0]        b_resp_i,
    output logic              ar_valid_o,
    input  logic              ar_ready_i,
    output logic [AW-1:0]     ar_addr_o,
    input  logic              r_valid_i,
    output logic              r_ready_o,
    input  logic [DW-1:0]     r_data_i,
    input  logic [1:0]        r_resp_i
);
    localparam int SW = DW / 8;

    state_e      state_q, state_d;
    logic [1:0]  idx_q, idx_d;
    logic [47:0] mac_q, mac_d;
    logic [7:0]  ctrl_q, ctrl_d;
    logic [15:0] len_q, len_d;
    logic [31:0] kick_q, kick_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [31:0] data_q, data_d;
    logic        aw_valid_q, aw_valid_d;
    logic        w_valid_q, w_valid_d;
    err_code_e   err_code_q, err_code_d;
    logic [1:0]  err_idx_q, err_idx_d;

    logic        go_wr;
    logic        fail;
    err_code_e   fail_code;
    logic        tmo_expired;
    logic [1:0]  next_idx;
    seq_entry_t  ent;
    logic        aw_done, w_done;

    // The next write entry: from live inputs when starting, else from the captured copy.
    always_comb begin
        if (state_q == ST_IDLE) begin
            next_idx = 2'd0;
            ent      = seq_entry(2'd0, mac_addr_i, ctrl_i, tx_len_i, kick_val_i);
        end else begin
            next_idx = idx_q + 2'd1;
            ent      = seq_entry(idx_q + 2'd1, mac_q, ctrl_q, len_q, kick_q);
        end
    end

    assign aw_done = !aw_valid_q || aw_ready_i;
    assign w_done  = !w_valid_q  || w_ready_i;

    // Sequencer next-state and datapath updates.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        mac_d      = mac_q;
        ctrl_d     = ctrl_q;
        len_d      = len_q;
        kick_d     = kick_q;
        addr_d     = addr_q;
        data_d     = data_q;
        aw_valid_d = aw_valid_q;
        w_valid_d  = w_valid_q;
        err_code_d = err_code_q;
        err_idx_d  = err_idx_q;
        go_wr      = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    mac_d      = mac_addr_i;
                    ctrl_d     = ctrl_i;
                    len_d      = tx_len_i;
                    kick_d     = kick_val_i;
                    err_code_d = ERR_NONE;
                    err_idx_d  = 2'd0;
                    go_wr      = 1'b1;
                end
            end
            ST_WR: begin
                if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else begin
                    if (aw_valid_q && aw_ready_i) aw_valid_d = 1'b0;
                    if (w_valid_q && w_ready_i)   w_valid_d  = 1'b0;
                    if (aw_done && w_done)        state_d    = ST_WRESP;
                end
            end
            ST_WRESP: begin
                if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (b_valid_i) begin
                    if (b_resp_i[1]) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (idx_q == 2'd3) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef ETH_CFG_READBACK_EN
                        state_d = ST_RD;
`else
                        go_wr = 1'b1;
`endif
                    end
                end
            end
`ifdef ETH_CFG_READBACK_EN
            ST_RD: begin
                if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (ar_ready_i) begin
                    state_d = ST_RRESP;
                end
            end
            ST_RRESP: begin
                if (tmo_expired) begin
                    fail      = 1'b1;
                    fail_code = ERR_TIMEOUT;
                end else if (r_valid_i) begin
                    if (r_resp_i[1]) begin
                        fail      = 1'b1;
                        fail_code = ERR_RESP;
                    end else if (r_data_i[31:0] != data_q) begin
                        fail      = 1'b1;
                        fail_code = ERR_MISMATCH;
                    end else begin
                        go_wr = 1'b1;
                    end
                end
            end
`endif
            ST_DONE:  state_d = ST_IDLE;
            ST_ERR:   state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase

        if (go_wr) begin
            state_d    = ST_WR;
            idx_d      = next_idx;
            addr_d     = BASE_ADDR + AW'(ent.offset);
            data_d     = ent.data;
            aw_valid_d = 1'b1;
            w_valid_d  = 1'b1;
        end

        // Abort drops both write valids at once, even mid-handshake.
        if (fail) begin
            state_d    = ST_ERR;
            err_code_d = fail_code;
            err_idx_d  = idx_q;
            aw_valid_d = 1'b0;
            w_valid_d  = 1'b0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= ST_IDLE;
            idx_q      <= 2'd0;
            mac_q      <= '0;
            ctrl_q     <= '0;
            len_q      <= '0;
            kick_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
            aw_valid_q <= 1'b0;
            w_valid_q  <= 1'b0;
            err_code_q <= ERR_NONE;
            err_idx_q  <= 2'd0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            mac_q      <= mac_d;
            ctrl_q     <= ctrl_d;
            len_q      <= len_d;
            kick_q     <= kick_d;
            addr_q     <= addr_d;
            data_q     <= data_d;
            aw_valid_q <= aw_valid_d;
            w_valid_q  <= w_valid_d;
            err_code_q <= err_code_d;
            err_idx_q  <= err_idx_d;
        end
    end

    eth_cfg_sequencer_timeout #(
        .LIMIT (TIMEOUT_CYC)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .load_i    (go_wr),
        .en_i      (busy_o),
        .expired_o (tmo_expired)
    );

    assign busy_o     = (state_q == ST_WR) || (state_q == ST_WRESP) ||
                        (state_q == ST_RD) || (state_q == ST_RRESP);
    assign done_o     = (state_q == ST_DONE);
    assign err_o      = (state_q == ST_ERR);
    assign err_code_o = err_code_q;
    assign err_idx_o  = err_idx_q;

    assign aw_valid_o = aw_valid_q;
    assign aw_addr_o  = addr_q;
    assign aw_id_o    = '0;
    assign w_valid_o  = w_valid_q;
    assign w_data_o   = DW'(data_q);
    assign w_strb_o   = SW'(4'hF);
    assign w_last_o   = w_valid_q;
    assign b_ready_o  = (state_q == ST_WRESP);

`ifdef ETH_CFG_READBACK_EN
    assign ar_valid_o = (state_q == ST_RD);
    assign ar_addr_o  = addr_q;
    assign r_ready_o  = (state_q == ST_RRESP);

    logic unused_rd;
    assign unused_rd = ^{r_data_i, r_resp_i[0], b_resp_i[0]};
`else
    assign ar_valid_o = 1'b0;
    assign ar_addr_o  = '0;
    assign r_ready_o  = 1'b0;

    logic unused_rd;
    assign unused_rd = ^{ar_ready_i, r_valid_i, r_data_i, r_resp_i, b_resp_i[0]};
`endif

endmodule

// File: tb/tb_eth_cfg_sequencer.sv
// Bench for eth_cfg_sequencer: a small AXI slave model commits each write
// (one cycle after both AW and W are taken, then answers B a cycle later)
// and compares it against the expected-write queue filled by the driver.
module tb_eth_cfg_sequencer;

    localparam int AW = 32;
    localparam int DW = 64;
    localparam int IW = 8;
`ifdef ETH_CFG_READBACK_EN
    localparam int EXP_LAT = 19;
`else
    localparam int EXP_LAT = 13;
`endif

    logic          clk, rst;
    logic          start_i;
    logic [47:0]   mac_addr_i;
    logic [7:0]    ctrl_i;
    logic [15:0]   tx_len_i;
    logic [31:0]   kick_val_i;
    logic          busy_o, done_o, err_o;
    logic [1:0]    err_code_o, err_idx_o;
    logic          aw_valid_o, aw_ready_i;
    logic [AW-1:0] aw_addr_o;
    logic [IW-1:0] aw_id_o;
    logic          w_valid_o, w_ready_i;
    logic [DW-1:0] w_data_o;
    logic [DW/8-1:0] w_strb_o;
    logic          w_last_o;
    logic          b_valid_i, b_ready_o;
    logic [1:0]    b_resp_i;
    logic          ar_valid_o, ar_ready_i;
    logic [AW-1:0] ar_addr_o;
    logic          r_valid_i, r_ready_o;
    logic [DW-1:0] r_data_i;
    logic [1:0]    r_resp_i;

    int n_checks = 0;
    int n_fail   = 0;
    logic [63:0] exp_q[$];

    // slave knobs
    logic        aw_block = 1'b0;
    int          aw_delay = 0;
    int          aw_wait;
    logic [31:0] fail_addr = 32'hFFFF_FFFF;
    logic        rd_corrupt = 1'b0;

    eth_cfg_sequencer #(
        .AW(AW), .DW(DW), .IW(IW), .BASE_ADDR(32'h800), .TIMEOUT_CYC(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .start_i(start_i),
        .mac_addr_i(mac_addr_i), .ctrl_i(ctrl_i), .tx_len_i(tx_len_i), .kick_val_i(kick_val_i),
        .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
        .err_code_o(err_code_o), .err_idx_o(err_idx_o),
        .aw_valid_o(aw_valid_o), .aw_ready_i(aw_ready_i), .aw_addr_o(aw_addr_o), .aw_id_o(aw_id_o),
        .w_valid_o(w_valid_o), .w_ready_i(w_ready_i), .w_data_o(w_data_o),
        .w_strb_o(w_strb_o), .w_last_o(w_last_o),
        .b_valid_i(b_valid_i), .b_ready_o(b_ready_o), .b_resp_i(b_resp_i),
        .ar_valid_o(ar_valid_o), .ar_ready_i(ar_ready_i), .ar_addr_o(ar_addr_o),
        .r_valid_i(r_valid_i), .r_ready_o(r_ready_o), .r_data_i(r_data_i), .r_resp_i(r_resp_i)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- check task ----------------
    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- slave model ----------------
    logic        aw_got, w_got;
    logic [31:0] s_addr;
    logic [63:0] s_data;
    logic [7:0]  s_strb;
    logic [31:0] mem [64];
    logic [63:0] exp_item;

    assign aw_ready_i = !aw_block && (aw_wait >= aw_delay);
    assign w_ready_i  = 1'b1;
    assign ar_ready_i = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            aw_got    <= 1'b0;
            w_got     <= 1'b0;
            aw_wait   <= 0;
            b_valid_i <= 1'b0;
            b_resp_i  <= 2'b00;
            r_valid_i <= 1'b0;
            r_data_i  <= '0;
            r_resp_i  <= 2'b00;
            s_addr    <= '0;
            s_data    <= '0;
            s_strb    <= '0;
        end else begin
            if (aw_valid_o && aw_ready_i) begin
                aw_got  <= 1'b1;
                s_addr  <= aw_addr_o;
                aw_wait <= 0;
            end else if (aw_valid_o) begin
                aw_wait <= aw_wait + 1;
            end
            if (w_valid_o && w_ready_i) begin
                w_got  <= 1'b1;
                s_data <= w_data_o;
                s_strb <= w_strb_o;
            end
            if (aw_got && w_got && !b_valid_i) begin
                check("wr_pending", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    exp_item = exp_q.pop_front();
                    check("wr", {s_addr, s_data[31:0]}, exp_item);
                end
                check("wr_strb_hi", {24'h0, s_strb, s_data[63:32]}, {24'h0, 8'h0F, 32'h0});
                mem[s_addr[7:2]] <= s_data[31:0];
                b_valid_i <= 1'b1;
                b_resp_i  <= (s_addr == fail_addr) ? 2'b10 : 2'b00;
                aw_got    <= 1'b0;
                w_got     <= 1'b0;
            end
            if (b_valid_i && b_ready_o) b_valid_i <= 1'b0;
            if (ar_valid_o && ar_ready_i) begin
                r_valid_i <= 1'b1;
                r_resp_i  <= 2'b00;
                r_data_i  <= (rd_corrupt && ar_addr_o == 32'h800) ? 64'h0089_0703
                                                                  : {32'h0, mem[ar_addr_o[7:2]]};
            end
            if (r_valid_i && r_ready_o) r_valid_i <= 1'b0;
        end
    end

    // ---------------- protocol monitor ----------------
    logic        mon_en = 1'b0;
    logic        w_first_seen;
    int          addr_unstable, valid_withdrawn, ar_valid_cnt, ar_828_cnt;
    logic        prev_aw_valid, prev_aw_acc;
    logic [31:0] prev_addr;

    initial begin
        ar_valid_cnt = 0;
        ar_828_cnt   = 0;
    end

    always @(negedge clk) begin
        if (ar_valid_o) ar_valid_cnt++;
        if (ar_valid_o && ar_ready_i && ar_addr_o == 32'h828) ar_828_cnt++;
        if (mon_en) begin
            if (aw_valid_o && !w_valid_o) w_first_seen = 1'b1;
            if (prev_aw_valid && !prev_aw_acc && !aw_valid_o) valid_withdrawn++;
            if (prev_aw_valid && !prev_aw_acc && aw_valid_o && aw_addr_o != prev_addr) addr_unstable++;
        end
        prev_aw_valid = aw_valid_o;
        prev_aw_acc   = aw_valid_o && aw_ready_i;
        prev_addr     = aw_addr_o;
    end

    // ---------------- driver tasks ----------------
    task automatic set_inputs(input logic [47:0] mac, input logic [7:0] ctrl,
                              input logic [15:0] len, input logic [31:0] kick);
        mac_addr_i = mac;
        ctrl_i     = ctrl;
        tx_len_i   = len;
        kick_val_i = kick;
    endtask

    // expected {addr, data} of the first n writes for the given inputs
    task automatic push_seq(input logic [47:0] mac, input logic [7:0] ctrl,
                            input logic [15:0] len, input logic [31:0] kick, input int n);
        if (n > 0) exp_q.push_back({32'h800, mac[31:0]});
        if (n > 1) exp_q.push_back({32'h808, 8'h00, ctrl, mac[47:32]});
        if (n > 2) exp_q.push_back({32'h810, 16'h0000, len});
        if (n > 3) exp_q.push_back({32'h828, kick});
    endtask

    // returns at the negedge of the first cycle after start_i was sampled
    task automatic pulse_start();
        @(negedge clk);
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
    endtask

    // waits for done_o/err_o; lat = cycles after the start edge; pokes start_i at cycle poke_at
    task automatic run_wait(input int limit, input int poke_at,
                            output int lat, output logic saw_done, output logic saw_err);
        lat = 1;
        while (!done_o && !err_o && lat < limit) begin
            @(negedge clk);
            lat++;
            start_i = (lat == poke_at);
        end
        start_i  = 1'b0;
        saw_done = done_o;
        saw_err  = err_o;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // ---------------- main sequence ----------------
    int          lat;
    logic        sd, se;
    int          guard;
    logic [47:0] r_mac;
    logic [7:0]  r_ctrl;
    logic [15:0] r_len;
    logic [31:0] r_kick;

    initial begin
        rst     = 1'b1;
        start_i = 1'b0;
        set_inputs('0, '0, '0, '0);
        idle_cycles(3);

        // reset state
        check("rst_ctl", {56'h0, busy_o, done_o, err_o, aw_valid_o, w_valid_o, b_ready_o, ar_valid_o, r_ready_o}, 64'h0);
        check("rst_err", {60'h0, err_code_o, err_idx_o}, 64'h0);
        check("rst_addr", {32'h0, aw_addr_o}, 64'h0);
        check("rst_data", w_data_o, 64'h0);
        rst = 1'b0;
        idle_cycles(2);

        // basic run with the reference values
        set_inputs(48'h0123_0089_0702, 8'h00, 16'h0010, 32'h8);
        exp_q.push_back({32'h800, 32'h0089_0702});
        exp_q.push_back({32'h808, 32'h0000_0123});
        exp_q.push_back({32'h810, 32'h0000_0010});
        exp_q.push_back({32'h828, 32'h0000_0008});
        pulse_start();
        check("busy_first_wr", {63'h0, busy_o}, 64'd1);
        check("awv_first_wr", {62'h0, aw_valid_o, w_valid_o}, 64'd3);
        run_wait(60, 0, lat, sd, se);
        check("basic_done", {62'h0, sd, se}, 64'd2);
        check("basic_lat", 64'(lat), 64'(EXP_LAT));
        check("busy_in_done", {63'h0, busy_o}, 64'd0);
        check("basic_code", {62'h0, err_code_o}, 64'd0);
        @(negedge clk);
        check("done_pulse", {63'h0, done_o}, 64'd0);
        check("basic_q_empty", 64'(exp_q.size()), 64'd0);

        // AW held off for 5 cycles, W accepted immediately
        aw_delay      = 5;
        w_first_seen  = 1'b0;
        addr_unstable = 0;
        valid_withdrawn = 0;
        mon_en        = 1'b1;
        set_inputs(48'hA1B2_C3D4_E5F6, 8'h81, 16'h05EE, 32'hDEAD_BEEF);
        push_seq(48'hA1B2_C3D4_E5F6, 8'h81, 16'h05EE, 32'hDEAD_BEEF, 4);
        pulse_start();
        run_wait(200, 0, lat, sd, se);
        mon_en   = 1'b0;
        aw_delay = 0;
        check("awdly_done", {62'h0, sd, se}, 64'd2);
        check("awdly_w_first", {63'h0, w_first_seen}, 64'd1);
        check("awdly_addr_stable", 64'(addr_unstable), 64'd0);
        check("awdly_no_withdraw", 64'(valid_withdrawn), 64'd0);
        check("awdly_q_empty", 64'(exp_q.size()), 64'd0);
        idle_cycles(2);

        // error response on the 'h810 write
        fail_addr = 32'h810;
        set_inputs(48'h1122_3344_5566, 8'h40, 16'h0040, 32'h1);
        push_seq(48'h1122_3344_5566, 8'h40, 16'h0040, 32'h1, 3);
        pulse_start();
        run_wait(60, 0, lat, sd, se);
        check("bresp_err", {62'h0, sd, se}, 64'd1);
        check("bresp_code", {62'h0, err_code_o}, 64'd1);
        check("bresp_idx", {62'h0, err_idx_o}, 64'd2);
        idle_cycles(8);
        check("bresp_held", {60'h0, err_code_o, err_idx_o}, 64'h6);
        check("bresp_no_828", 64'(exp_q.size()), 64'd0);
        check("bresp_idle", {62'h0, busy_o, err_o}, 64'd0);
        fail_addr = 32'hFFFF_FFFF;

        // AW never accepted: watchdog after 16 cycles
        aw_block = 1'b1;
        set_inputs(48'h0000_0000_00AA, 8'h00, 16'h0001, 32'h2);
        pulse_start();
        run_wait(60, 0, lat, sd, se);
        check("tmo_err", {62'h0, sd, se}, 64'd1);
        check("tmo_lat", 64'(lat), 64'd17);
        check("tmo_code", {60'h0, err_code_o, err_idx_o}, 64'h8);
        check("tmo_valids_drop", {62'h0, aw_valid_o, w_valid_o}, 64'd0);
        @(negedge clk);
        check("tmo_busy_after", {62'h0, busy_o, err_o}, 64'd0);
        aw_block = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("tmo_rst_clears", {60'h0, err_code_o, err_idx_o}, 64'h0);
        idle_cycles(2);

        // second start mid-sequence and start in the DONE cycle are both dropped
        r_mac  = {16'($urandom_range(0, 65535)), 32'($urandom)};
        r_ctrl = 8'($urandom_range(0, 255));
        r_len  = 16'($urandom_range(1, 1500));
        r_kick = 32'($urandom);
        set_inputs(r_mac, r_ctrl, r_len, r_kick);
        push_seq(r_mac, r_ctrl, r_len, r_kick, 4);
        pulse_start();
        set_inputs(~r_mac, ~r_ctrl, ~r_len, ~r_kick);
        run_wait(60, 5, lat, sd, se);
        check("mid_done", {62'h0, sd, se}, 64'd2);
        check("mid_lat", 64'(lat), 64'(EXP_LAT));
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("start_in_done_dropped", {63'h0, busy_o}, 64'd0);
        idle_cycles(20);
        check("mid_q_empty", 64'(exp_q.size()), 64'd0);
        check("mid_no_rerun", {63'h0, busy_o}, 64'd0);

        // asynchronous reset during WRESP, then a fresh run from idx 0
        set_inputs(48'h0123_0089_0702, 8'h00, 16'h0010, 32'h8);
        pulse_start();
        guard = 0;
        while (!b_ready_o && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check("rst_reach_wresp", {63'h0, b_ready_o}, 64'd1);
        rst = 1'b1;
        #1;
        check("arst_ctl", {58'h0, busy_o, done_o, err_o, aw_valid_o, w_valid_o, b_ready_o}, 64'h0);
        check("arst_addr", {aw_addr_o, w_data_o[31:0]}, 64'h0);
        @(negedge clk);
        rst = 1'b0;
        idle_cycles(2);
        push_seq(48'h0123_0089_0702, 8'h00, 16'h0010, 32'h8, 4);
        pulse_start();
        run_wait(60, 0, lat, sd, se);
        check("rerun_done", {62'h0, sd, se}, 64'd2);
        check("rerun_lat", 64'(lat), 64'(EXP_LAT));
        idle_cycles(2);
        check("rerun_q_empty", 64'(exp_q.size()), 64'd0);

`ifdef ETH_CFG_READBACK_EN
        // readback returns a wrong value for 'h800
        rd_corrupt = 1'b1;
        push_seq(48'h0123_0089_0702, 8'h00, 16'h0010, 32'h8, 1);
        pulse_start();
        run_wait(60, 0, lat, sd, se);
        check("rb_err", {62'h0, sd, se}, 64'd1);
        check("rb_lat", 64'(lat), 64'd6);
        check("rb_code", {60'h0, err_code_o, err_idx_o}, 64'hC);
        rd_corrupt = 1'b0;
        idle_cycles(2);
        check("rb_no_ar_828", 64'(ar_828_cnt), 64'd0);
`else
        check("no_ar_issued", 64'(ar_valid_cnt), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
